// File: rtl/digit_scan_ctrl_pkg.sv
// Shared display definitions for the 4-digit scan controller.
// Holds the digit count, nibble width, FSM state encoding and a sizing helper.
package digit_scan_ctrl_pkg;

    localparam int NDIGITS = 4;
    localparam int NIB_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_scan_timer.sv
// Dwell/blank slot counter: counts cycles inside a SHOW or GAP slot and
// strobes the last cycle of each, restarting at 0 on every strobe.
module scan_timer
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_show,
    input  logic i_gap,
    output logic o_show_end,
    output logic o_gap_end
);

    localparam int CW = $clog2(max3(DWELL, BLANK, 2));
    localparam logic [CW-1:0] SHOW_LAST = CW'(DWELL - 1);
    // With no blank slot the GAP compare value is never used; keep it in range.
    localparam logic [CW-1:0] GAP_LAST  = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    logic [CW-1:0] r_cnt;

    assign o_show_end = i_show && (r_cnt == SHOW_LAST);
    assign o_gap_end  = (BLANK > 0) && i_gap && (r_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt <= '0;
        end else if (o_show_end || o_gap_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with dwell/blank timing,
// frame-aligned (tear-free) digit updates and leading-zero blanking.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_digits,
    input  logic        i_lzb,
    output logic        o_e,
    output logic [1:0]  o_data_out,
    output logic [3:0]  o_nibble,
    output logic        o_frame_done,
    output logic [1:0]  o_dbg_state
);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic        r_pending;
    logic        r_frame_done;
    logic        r_lzb;

    logic w_run;
    logic w_show_end;
    logic w_gap_end;
    logic w_boundary;
    logic w_blank;

    // Digit k is dark when it and every more significant digit are zero.
    function automatic logic lz_blank(input logic [15:0] a, input logic [1:0] k);
        case (k)
            2'd3:    return a[15:12] == 4'd0;
            2'd2:    return a[15:8] == 8'd0;
            2'd1:    return a[15:4] == 12'd0;
            default: return 1'b0;
        endcase
    endfunction

    assign w_run = i_en && (r_state != ST_IDLE);

    scan_timer #(
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_run),
        .i_show    (r_state == ST_SHOW),
        .i_gap     (r_state == ST_GAP),
        .o_show_end(w_show_end),
        .o_gap_end (w_gap_end)
    );

    // Last cycle of digit 3's slot; a dropped enable cancels it.
    assign w_boundary = i_en && (r_idx == 2'(NDIGITS - 1))
                        && ((BLANK > 0) ? w_gap_end : w_show_end);

    assign w_blank      = r_lzb && lz_blank(r_active, r_idx);
    assign o_e          = (r_state != ST_SHOW) || w_blank;
    assign o_data_out   = r_idx;
    assign o_nibble     = r_active[{r_idx, 2'b00} +: NIB_W];
    assign o_frame_done = r_frame_done;
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= 2'd0;
            r_active     <= 16'd0;
            r_shadow     <= 16'd0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_lzb        <= 1'b0;
        end else begin
            r_lzb        <= i_lzb;
            r_frame_done <= w_boundary;

            if (w_boundary) begin
                if (i_load) begin
                    r_active  <= i_digits;
                    r_shadow  <= i_digits;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else if (i_load) begin
                r_shadow  <= i_digits;
                r_pending <= 1'b1;
            end

            if (!i_en) begin
                r_state <= ST_IDLE;
                r_idx   <= 2'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SHOW;
                        r_idx   <= 2'd0;
                    end
                    ST_SHOW: begin
                        if (w_show_end) begin
                            if (BLANK > 0) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_idx <= r_idx + 2'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_end) begin
                            r_state <= ST_SHOW;
                            r_idx   <= r_idx + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_idx   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: a BLANK=2 and a BLANK=0 instance share stimulus
// and are compared every cycle against a frame-position model.
module tb_digit_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] digits;
    logic        lzb;

    logic       a_e, b_e;
    logic [1:0] a_sel, b_sel;
    logic [3:0] a_nib, b_nib;
    logic       a_fd, b_fd;
    logic [1:0] a_st, b_st;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    digit_scan_ctrl #(.DWELL(4), .BLANK(2)) dut_a (
        .clk(clk), .rst(rst), .i_en(en), .i_load(load), .i_digits(digits),
        .i_lzb(lzb), .o_e(a_e), .o_data_out(a_sel), .o_nibble(a_nib),
        .o_frame_done(a_fd), .o_dbg_state(a_st)
    );

    digit_scan_ctrl #(.DWELL(4), .BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .i_en(en), .i_load(load), .i_digits(digits),
        .i_lzb(lzb), .o_e(b_e), .o_data_out(b_sel), .o_nibble(b_nib),
        .o_frame_done(b_fd), .o_dbg_state(b_st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: position t counts cycles since the first lit cycle
    int          m_slot[2] = '{6, 4};
    bit          m_run[2]  = '{0, 0};
    int          m_t[2]    = '{0, 0};
    logic [15:0] m_act[2]  = '{16'd0, 16'd0};
    logic [15:0] m_sh[2]   = '{16'd0, 16'd0};
    bit          m_pend[2] = '{0, 0};
    bit          m_fd[2]   = '{0, 0};
    bit          m_lzq[2]  = '{0, 0};

    function automatic int pos(input int i);
        return m_t[i] % (4 * m_slot[i]);
    endfunction

    function automatic logic [1:0] exp_idx(input int i);
        return m_run[i] ? 2'(pos(i) / m_slot[i]) : 2'd0;
    endfunction

    function automatic logic exp_e(input int i);
        logic [1:0] k;
        if (!m_run[i]) return 1'b1;
        k = exp_idx(i);
        if ((pos(i) % m_slot[i]) >= 4) return 1'b1;
        if (m_lzq[i] && k != 2'd0 && (m_act[i] >> (4 * k)) == 16'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_nib(input int i);
        logic [15:0] s;
        s = m_act[i] >> (4 * exp_idx(i));
        return s[3:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 0; m_t[i] = 0; m_act[i] = 16'd0; m_sh[i] = 16'd0;
                m_pend[i] = 0; m_fd[i] = 0; m_lzq[i] = 0;
            end else begin
                bit bd;
                bd = m_run[i] && en && (pos(i) == 4 * m_slot[i] - 1);
                m_lzq[i] = lzb;
                m_fd[i]  = bd;
                if (bd) begin
                    if (load) begin
                        m_act[i] = digits; m_sh[i] = digits; m_pend[i] = 0;
                    end else if (m_pend[i]) begin
                        m_act[i] = m_sh[i]; m_pend[i] = 0;
                    end
                end else if (load) begin
                    m_sh[i] = digits; m_pend[i] = 1;
                end
                if (!en) begin
                    m_run[i] = 0; m_t[i] = 0;
                end else if (!m_run[i]) begin
                    m_run[i] = 1; m_t[i] = 0;
                end else begin
                    m_t[i] = m_t[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // scoreboard compare, once per cycle away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_e",   16'(a_e),   16'(exp_e(0)));
            check("a_sel", 16'(a_sel), 16'(exp_idx(0)));
            check("a_nib", 16'(a_nib), 16'(exp_nib(0)));
            check("a_fd",  16'(a_fd),  16'(m_fd[0]));
            check("b_e",   16'(b_e),   16'(exp_e(1)));
            check("b_sel", 16'(b_sel), 16'(exp_idx(1)));
            check("b_nib", 16'(b_nib), 16'(exp_nib(1)));
            check("b_fd",  16'(b_fd),  16'(m_fd[1]));
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_p(input int target);
        for (int k = 0; k < 60; k++) begin
            if (m_run[0] && pos(0) == target) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_p: position %0d not reached, at %0d", target, pos(0));
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int n = 0; n < 4; n++)
            d[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return d;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; digits = 16'd0; lzb = 1'b0;
        step();
        chk_on = 1;
        step();
        rst = 1'b0;
        check("rst_e",   16'(a_e),   16'd1);
        check("rst_sel", 16'(a_sel), 16'd0);
        check("rst_nib", 16'(a_nib), 16'd0);
        check("rst_fd",  16'(a_fd),  16'd0);

        // 1234 loaded while idle, appears from the first frame boundary
        load = 1'b1; digits = 16'h1234;
        step();
        load = 1'b0; en = 1'b1;
        step();
        check("t0_e",   16'(a_e),   16'd0);
        check("t0_nib", 16'(a_nib), 16'd0);
        repeat (16) step();
        check("b16_fd",  16'(b_fd),  16'd1);
        check("b16_nib", 16'(b_nib), 16'h4);
        repeat (8) step();
        check("t24_fd",  16'(a_fd),  16'd1);
        check("t24_nib", 16'(a_nib), 16'h4);
        check("b24_sel", 16'(b_sel), 16'd2);
        check("b24_nib", 16'(b_nib), 16'h2);
        repeat (4) step();
        check("t28_e", 16'(a_e), 16'd1);
        repeat (2) step();
        check("t30_sel", 16'(a_sel), 16'd1);
        check("t30_nib", 16'(a_nib), 16'h3);
        check("t30_fd",  16'(a_fd),  16'd0);

        // mid-frame load waits for the boundary
        load = 1'b1; digits = 16'h0001;
        step();
        load = 1'b0;
        wait_p(23);
        check("old_nib", 16'(a_nib), 16'h1);
        check("old_sel", 16'(a_sel), 16'd3);
        step();
        check("new_fd",  16'(a_fd),  16'd1);
        check("new_nib", 16'(a_nib), 16'h1);
        wait_p(6);
        check("new_d1", 16'(a_nib), 16'h0);

        // load on the boundary cycle bypasses into active
        wait_p(23);
        load = 1'b1; digits = 16'h5678;
        step();
        load = 1'b0;
        check("byp_nib", 16'(a_nib), 16'h8);
        wait_p(23);
        step();
        check("byp_keep", 16'(a_nib), 16'h8);

        // leading-zero blanking of 0050
        load = 1'b1; digits = 16'h0050; lzb = 1'b1;
        step();
        load = 1'b0;
        wait_p(23);
        step();
        wait_p(1);
        check("lz_d0_e",   16'(a_e),   16'd0);
        check("lz_d0_nib", 16'(a_nib), 16'h0);
        wait_p(7);
        check("lz_d1_e",   16'(a_e),   16'd0);
        check("lz_d1_nib", 16'(a_nib), 16'h5);
        wait_p(13);
        check("lz_d2_e", 16'(a_e), 16'd1);
        wait_p(19);
        check("lz_d3_e",   16'(a_e),   16'd1);
        check("lz_d3_sel", 16'(a_sel), 16'd3);
        lzb = 1'b0;

        // enable dropped during digit 2 SHOW
        wait_p(13);
        en = 1'b0;
        step();
        check("off_e",   16'(a_e),   16'd1);
        check("off_sel", 16'(a_sel), 16'd0);
        check("off_fd",  16'(a_fd),  16'd0);
        en = 1'b1;
        step();
        check("on_sel", 16'(a_sel), 16'd0);
        check("on_e",   16'(a_e),   16'd0);

        // reset together with a load discards the load
        wait_p(9);
        rst = 1'b1; load = 1'b1; digits = 16'hffff;
        step();
        rst = 1'b0; load = 1'b0;
        check("rl_e",   16'(a_e),   16'd1);
        check("rl_sel", 16'(a_sel), 16'd0);
        check("rl_nib", 16'(a_nib), 16'h0);
        check("rl_fd",  16'(a_fd),  16'd0);
        step();
        wait_p(23);
        step();
        check("rl_act", 16'(a_nib), 16'h0);
        check("rl_fd2", 16'(a_fd),  16'd1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 299) == 0);
            en     = ($urandom_range(0, 49) != 0);
            load   = ($urandom_range(0, 7) == 0);
            digits = rand_digits();
            if ($urandom_range(0, 29) == 0) lzb = ~lzb;
            step();
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;
        step();

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
